// File: rtl/npu_vec_responder.sv
`default_nettype none
// ============================================================================
// Module      : npu_vec_responder
// Description : Vector multiply responder. Reads A[i] and B[i] from shared
//               memory, writes C[i] = A[i]*B[i], then acks the initiator.
//               Define NPU_SAT_EN to saturate the product instead of wrapping.
// Revision    : 1.0  initial release
// ============================================================================
module npu_vec_responder #(
    parameter int VEC_LEN = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [7:0]  src1_addr,
    input  logic [7:0]  src2_addr,
    input  logic [7:0]  rd_addr,
    output logic        ack,
    output logic        MEMRead,
    output logic        MEMWrite,
    output logic [31:0] ADDR,
    output logic [31:0] WD,
    input  logic [31:0] RD
);

    localparam logic [2:0] c_IDLE = 3'd0;
    localparam logic [2:0] c_RA   = 3'd1;
    localparam logic [2:0] c_RB   = 3'd2;
    localparam logic [2:0] c_WR   = 3'd3;
    localparam logic [2:0] c_DONE = 3'd4;

    localparam logic [5:0] c_LAST_IDX = 6'(VEC_LEN - 1);

    logic [2:0]  r_state;
    logic [7:0]  r_src1;
    logic [7:0]  r_src2;
    logic [7:0]  r_rd;
    logic [5:0]  r_idx;
    logic [31:0] r_a;

    logic [7:0]  w_idx8;
    logic [7:0]  w_word;
    logic [31:0] w_f;

    assign w_idx8 = {2'b00, r_idx};

`ifdef NPU_SAT_EN
    logic signed [63:0] w_prod;

    assign w_prod = 64'($signed(r_a)) * 64'($signed(RD));

    // Product fits in 32 bits only when bits 63..31 are all copies of the sign.
    always_comb begin
        if (w_prod[63:31] != {33{w_prod[63]}}) begin
            w_f = w_prod[63] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end else begin
            w_f = w_prod[31:0];
        end
    end
`else
    // Low word of a product is the same for signed and unsigned operands.
    assign w_f = r_a * RD;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_src1  <= 8'd0;
            r_src2  <= 8'd0;
            r_rd    <= 8'd0;
            r_idx   <= 6'd0;
            r_a     <= 32'd0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (en) begin
                        r_src1  <= src1_addr;
                        r_src2  <= src2_addr;
                        r_rd    <= rd_addr;
                        r_idx   <= 6'd0;
                        r_state <= c_RA;
                    end
                end
                c_RA: begin
                    r_state <= en ? c_RB : c_IDLE;
                end
                c_RB: begin
                    r_a     <= RD;
                    r_state <= en ? c_WR : c_IDLE;
                end
                c_WR: begin
                    if (!en) begin
                        r_state <= c_IDLE;
                    end else if (r_idx == c_LAST_IDX) begin
                        r_state <= c_DONE;
                    end else begin
                        r_idx   <= r_idx + 6'd1;
                        r_state <= c_RA;
                    end
                end
                c_DONE: begin
                    if (!en) begin
                        r_state <= c_IDLE;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        ack      = 1'b0;
        MEMRead  = 1'b0;
        MEMWrite = 1'b0;
        WD       = 32'd0;
        w_word   = 8'd0;
        case (r_state)
            c_RA: begin
                MEMRead = 1'b1;
                w_word  = r_src1 + w_idx8;
            end
            c_RB: begin
                MEMRead = 1'b1;
                w_word  = r_src2 + w_idx8;
            end
            c_WR: begin
                MEMWrite = 1'b1;
                w_word   = r_rd + w_idx8;
                WD       = w_f;
            end
            c_DONE: begin
                ack = 1'b1;
            end
            default: begin
                ack = 1'b0;
            end
        endcase
        ADDR = {22'd0, w_word, 2'b00};
    end

endmodule
`default_nettype wire

// File: tb/tb_npu_vec_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_npu_vec_responder
// Description : Directed self-checking bench for npu_vec_responder with a
//               word-addressed shared-memory model (NPU_SAT_EN aware).
// Revision    : 1.0  initial release
// ============================================================================
module tb_npu_vec_responder;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [7:0]  src1_addr;
    logic [7:0]  src2_addr;
    logic [7:0]  rd_addr;
    logic        ack;
    logic        MEMRead;
    logic        MEMWrite;
    logic [31:0] ADDR;
    logic [31:0] WD;
    logic [31:0] RD;

    logic [31:0] mem [256];
    logic        pl_we = 1'b0;
    logic [7:0]  pl_addr = 8'd0;
    logic [31:0] pl_data = 32'd0;

    int n_vec = 0;
    int n_err = 0;

    npu_vec_responder #(.VEC_LEN(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .src1_addr (src1_addr),
        .src2_addr (src2_addr),
        .rd_addr   (rd_addr),
        .ack       (ack),
        .MEMRead   (MEMRead),
        .MEMWrite  (MEMWrite),
        .ADDR      (ADDR),
        .WD        (WD),
        .RD        (RD)
    );

    always #5 clk = ~clk;

    // Shared memory: RD is registered, valid the cycle after MEMRead.
    always @(posedge clk) begin
        if (pl_we) mem[pl_addr] <= pl_data;
        else if (MEMWrite) mem[ADDR[9:2]] <= WD;
        if (MEMRead) RD <= mem[ADDR[9:2]];
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic poke(input logic [7:0] a, input logic [31:0] d);
        pl_we = 1'b1; pl_addr = a; pl_data = d;
        step;
        pl_we = 1'b0;
    endtask

    task automatic load_ab;
        for (int i = 0; i < 4; i++) begin
            poke(8'(8'h10 + i), 32'(i + 1));
            poke(8'(8'h20 + i), 32'(i + 5));
        end
    endtask

    task automatic start(input logic [7:0] s1, input logic [7:0] s2, input logic [7:0] rd);
        src1_addr = s1; src2_addr = s2; rd_addr = rd;
        en = 1'b1;
        step;
    endtask

    // Expected {MEMRead, MEMWrite, ADDR} in cycle c (1 = first cycle after start).
    function automatic logic [33:0] exp_bus(input logic [7:0] s1, input logic [7:0] s2,
                                            input logic [7:0] rd, input int c);
        int e, k;
        if (c < 1 || c > 3 * N) return 34'd0;
        e = (c - 1) / 3;
        k = (c - 1) % 3;
        if (k == 0) return {2'b10, 22'd0, 8'(s1 + e), 2'b00};
        if (k == 1) return {2'b10, 22'd0, 8'(s2 + e), 2'b00};
        return {2'b01, 22'd0, 8'(rd + e), 2'b00};
    endfunction

    task automatic test_reset;
        rst = 1'b1; en = 1'b0;
        src1_addr = 8'h00; src2_addr = 8'h00; rd_addr = 8'h00;
        step; step;
        n_vec++;
        if ({ack, MEMRead, MEMWrite, ADDR, WD} !== 67'd0) begin
            n_err++;
            $display("FAIL reset_outputs got %h exp 0", {ack, MEMRead, MEMWrite, ADDR, WD});
        end
        rst = 1'b0;
        step;
        n_vec++;
        if ({ack, MEMRead, MEMWrite, ADDR, WD} !== 67'd0) begin
            n_err++;
            $display("FAIL idle_outputs got %h exp 0", {ack, MEMRead, MEMWrite, ADDR, WD});
        end
    endtask

    task automatic test_basic;
        logic [31:0] prod [4];
        prod = '{32'd5, 32'd12, 32'd21, 32'd32};
        load_ab;
        start(8'h10, 8'h20, 8'h30);
        for (int c = 1; c <= 13; c++) begin
            n_vec++;
            if ({MEMRead, MEMWrite, ADDR} !== exp_bus(8'h10, 8'h20, 8'h30, c)) begin
                n_err++;
                $display("FAIL basic_bus c%0d got %h exp %h", c, {MEMRead, MEMWrite, ADDR},
                         exp_bus(8'h10, 8'h20, 8'h30, c));
            end
            if (c % 3 == 0 && c <= 12) begin
                n_vec++;
                if (WD !== prod[c / 3 - 1]) begin
                    n_err++;
                    $display("FAIL basic_wd c%0d got %h exp %h", c, WD, prod[c / 3 - 1]);
                end
            end
            n_vec++;
            if (ack !== (c == 13)) begin
                n_err++;
                $display("FAIL basic_ack c%0d got %b exp %b", c, ack, (c == 13));
            end
            if (c == 1) begin
                src1_addr = 8'hAA; src2_addr = 8'hBB; rd_addr = 8'hCC;
            end
            if (c < 13) step;
        end
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (mem[8'(8'h30 + i)] !== prod[i]) begin
                n_err++;
                $display("FAIL basic_mem w%0d got %h exp %h", i, mem[8'(8'h30 + i)], prod[i]);
            end
        end
        n_vec++;
        if (WD !== 32'd0 || ADDR !== 32'd0) begin
            n_err++;
            $display("FAIL done_addr_wd got %h/%h exp 0/0", ADDR, WD);
        end
        en = 1'b0;
        step; step;
    endtask

    task automatic test_wrap;
        logic [1:0]  rw   [12];
        logic [31:0] ad   [12];
        logic [31:0] prod [4];
        rw   = '{2'b10, 2'b10, 2'b01, 2'b10, 2'b10, 2'b01,
                 2'b10, 2'b10, 2'b01, 2'b10, 2'b10, 2'b01};
        ad   = '{32'h3F8, 32'h000, 32'h3F4, 32'h3FC, 32'h004, 32'h3F8,
                 32'h000, 32'h008, 32'h3FC, 32'h004, 32'h00C, 32'h000};
        prod = '{32'd8, 32'd15, 32'd24, 32'd35};
        poke(8'hFE, 32'd2); poke(8'hFF, 32'd3);
        poke(8'h00, 32'd4); poke(8'h01, 32'd5);
        poke(8'h02, 32'd6); poke(8'h03, 32'd7);
        start(8'hFE, 8'h00, 8'hFD);
        for (int c = 1; c <= 12; c++) begin
            n_vec++;
            if ({MEMRead, MEMWrite, ADDR} !== {rw[c - 1], ad[c - 1]}) begin
                n_err++;
                $display("FAIL wrap_bus c%0d got %h exp %h", c, {MEMRead, MEMWrite, ADDR},
                         {rw[c - 1], ad[c - 1]});
            end
            if (c % 3 == 0) begin
                n_vec++;
                if (WD !== prod[c / 3 - 1]) begin
                    n_err++;
                    $display("FAIL wrap_wd c%0d got %h exp %h", c, WD, prod[c / 3 - 1]);
                end
            end
            step;
        end
        n_vec++;
        if (ack !== 1'b1) begin
            n_err++;
            $display("FAIL wrap_ack got %b exp 1", ack);
        end
        en = 1'b0;
        step; step;
    endtask

    task automatic test_overflow;
        logic [31:0] av [4];
        logic [31:0] bv [4];
        logic [31:0] ex [4];
        av = '{32'h4000_0000, 32'h8000_0000, 32'hFFFF_FFFD, 32'h0001_0000};
        bv = '{32'd4, 32'd2, 32'd7, 32'h0001_0000};
`ifdef NPU_SAT_EN
        ex = '{32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFEB, 32'h7FFF_FFFF};
`else
        ex = '{32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFEB, 32'h0000_0000};
`endif
        for (int i = 0; i < 4; i++) begin
            poke(8'(8'h40 + i), av[i]);
            poke(8'(8'h48 + i), bv[i]);
        end
        start(8'h40, 8'h48, 8'h50);
        for (int c = 1; c <= 12; c++) begin
            if (c % 3 == 0) begin
                n_vec++;
                if (MEMWrite !== 1'b1 || WD !== ex[c / 3 - 1]) begin
                    n_err++;
                    $display("FAIL ovf_wd e%0d got we=%b wd=%h exp we=1 wd=%h", c / 3 - 1,
                             MEMWrite, WD, ex[c / 3 - 1]);
                end
            end
            step;
        end
        n_vec++;
        if (ack !== 1'b1) begin
            n_err++;
            $display("FAIL ovf_ack got %b exp 1", ack);
        end
        en = 1'b0;
        step; step;
    endtask

    task automatic test_abort;
        load_ab;
        poke(8'h70, 32'hDEAD_BEEF);
        poke(8'h71, 32'hDEAD_BEEF);
        start(8'h10, 8'h20, 8'h70);
        for (int c = 1; c <= 5; c++) begin
            n_vec++;
            if ({ack, MEMRead, MEMWrite, ADDR} !== {1'b0, exp_bus(8'h10, 8'h20, 8'h70, c)}) begin
                n_err++;
                $display("FAIL abort_bus c%0d got %h exp %h", c, {ack, MEMRead, MEMWrite, ADDR},
                         {1'b0, exp_bus(8'h10, 8'h20, 8'h70, c)});
            end
            if (c == 5) en = 1'b0;
            step;
        end
        for (int c = 6; c <= 15; c++) begin
            n_vec++;
            if ({ack, MEMRead, MEMWrite, ADDR, WD} !== 67'd0) begin
                n_err++;
                $display("FAIL abort_quiet c%0d got %h exp 0", c, {ack, MEMRead, MEMWrite, ADDR, WD});
            end
            step;
        end
        n_vec++;
        if (mem[8'h70] !== 32'd5 || mem[8'h71] !== 32'hDEAD_BEEF) begin
            n_err++;
            $display("FAIL abort_mem got %h/%h exp 00000005/deadbeef", mem[8'h70], mem[8'h71]);
        end
        start(8'h10, 8'h20, 8'h70);
        for (int c = 1; c <= 13; c++) begin
            n_vec++;
            if ({ack, MEMRead, MEMWrite, ADDR} !== {(c == 13), exp_bus(8'h10, 8'h20, 8'h70, c)}) begin
                n_err++;
                $display("FAIL restart_bus c%0d got %h exp %h", c, {ack, MEMRead, MEMWrite, ADDR},
                         {(c == 13), exp_bus(8'h10, 8'h20, 8'h70, c)});
            end
            if (c < 13) step;
        end
        n_vec++;
        if (mem[8'h71] !== 32'd12) begin
            n_err++;
            $display("FAIL restart_mem got %h exp 0000000c", mem[8'h71]);
        end
        en = 1'b0;
        step; step;
    endtask

    task automatic test_handshake;
        int c;
        start(8'h10, 8'h20, 8'h38);
        c = 1;
        while (ack !== 1'b1 && c < 20) begin
            step;
            c++;
        end
        n_vec++;
        if (c != 13) begin
            n_err++;
            $display("FAIL hs_ack_rise got cycle %0d exp 13", c);
        end
        for (int h = 0; h < 10; h++) begin
            n_vec++;
            if ({ack, MEMRead, MEMWrite, ADDR, WD} !== {1'b1, 66'd0}) begin
                n_err++;
                $display("FAIL hs_hold h%0d got %h exp %h", h, {ack, MEMRead, MEMWrite, ADDR, WD},
                         {1'b1, 66'd0});
            end
            step;
        end
        en = 1'b0;
        #1;
        n_vec++;
        if (ack !== 1'b1) begin
            n_err++;
            $display("FAIL hs_ack_before_fall got %b exp 1", ack);
        end
        step;
        n_vec++;
        if ({ack, MEMRead, MEMWrite, ADDR, WD} !== 67'd0) begin
            n_err++;
            $display("FAIL hs_ack_fall got %h exp 0", {ack, MEMRead, MEMWrite, ADDR, WD});
        end
        step;
    endtask

    task automatic test_reset_midrun;
        load_ab;
        poke(8'h5A, 32'hDEAD_BEEF);
        start(8'h10, 8'h20, 8'h58);
        for (int c = 1; c <= 8; c++) begin
            n_vec++;
            if (ack !== 1'b0) begin
                n_err++;
                $display("FAIL rstmid_ack c%0d got %b exp 0", c, ack);
            end
            step;
        end
        n_vec++;
        if ({MEMRead, MEMWrite, ADDR, WD} !== {2'b01, 32'h168, 32'd21}) begin
            n_err++;
            $display("FAIL rstmid_wr2 got %h exp %h", {MEMRead, MEMWrite, ADDR, WD},
                     {2'b01, 32'h168, 32'd21});
        end
        rst = 1'b1;
        step;
        n_vec++;
        if ({ack, MEMRead, MEMWrite, ADDR, WD} !== 67'd0) begin
            n_err++;
            $display("FAIL rstmid_zero got %h exp 0", {ack, MEMRead, MEMWrite, ADDR, WD});
        end
        n_vec++;
        if (mem[8'h5A] !== 32'd21) begin
            n_err++;
            $display("FAIL rstmid_mem got %h exp 00000015", mem[8'h5A]);
        end
        rst = 1'b0;
        step;
        n_vec++;
        if ({ack, MEMRead, MEMWrite, ADDR} !== {3'b010, 32'h040}) begin
            n_err++;
            $display("FAIL rstmid_restart got %h exp %h", {ack, MEMRead, MEMWrite, ADDR},
                     {3'b010, 32'h040});
        end
        en = 1'b0;
        step;
        n_vec++;
        if ({ack, MEMRead, MEMWrite, ADDR, WD} !== 67'd0) begin
            n_err++;
            $display("FAIL rstmid_idle got %h exp 0", {ack, MEMRead, MEMWrite, ADDR, WD});
        end
        step;
    endtask

    initial begin
        #1;
        test_reset;
        test_basic;
        test_wrap;
        test_overflow;
        test_abort;
        test_handshake;
        test_reset_midrun;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
